// File: rtl/voice_sequencer.sv
// voice_sequencer: per-sample master sequencer for the TT6581 audio datapath.
// Walks every voice through synthesis, envelope multiply and accumulation, then runs
// the optional SVF pass and the volume multiply before flagging a finished sample.
// Muted voices are skipped, the filter pass is skipped when nothing is routed to it,
// stuck handshakes are aborted by a watchdog and ticks arriving mid-frame are flagged.
module voice_sequencer #(
  parameter int NUM_VOICES     = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sample_tick_i,
  input  logic [NUM_VOICES-1:0] voice_mute_i,
  input  logic [NUM_VOICES-1:0] filt_en_i,
  input  logic                  voice_ready_i,
  input  logic                  env_ready_i,
  input  logic                  filt_ready_i,
  input  logic                  mult_ready_i,
  output logic [IDX_W-1:0]      voice_idx_o,
  output logic                  voice_start_o,
  output logic                  env_start_o,
  output logic                  filt_start_o,
  output logic                  mult_start_o,
  output logic [1:0]            mult_in_mux_o,
  output logic                  accum_en_o,
  output logic                  accum_rst_o,
  output logic                  accum_mux_o,
  output logic                  audio_valid_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  // The watchdog only has to reach TIMEOUT_CYCLES-1; expiry is decided on that value.
  localparam int WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WD_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [3:0] {
    IDLE, SEL, SYN, SYN_WAIT, ENV, ENV_WAIT, ACCUM,
    FILT, FILT_WAIT, VOL, VOL_WAIT, DONE
  } state_t;

  state_t                cur_state, nxt_state;
  logic [IDX_W-1:0]      cnt, cnt_d;
  logic [NUM_VOICES-1:0] mute_snap, filt_snap;
  logic [WD_W-1:0]       wd_cnt;

  logic       mute_sel, filt_sel, filt_any;
  logic       in_wait, nxt_in_wait, cur_ready, wd_expire;

  logic       voice_start_d, env_start_d, filt_start_d, mult_start_d;
  logic [1:0] mult_in_mux_d;
  logic       accum_en_d, accum_rst_d, accum_mux_d;
  logic       audio_valid_d, overrun_d, timeout_d;

  assign in_wait     = (cur_state == SYN_WAIT) || (cur_state == ENV_WAIT) ||
                       (cur_state == FILT_WAIT) || (cur_state == VOL_WAIT);
  assign nxt_in_wait = (nxt_state == SYN_WAIT) || (nxt_state == ENV_WAIT) ||
                       (nxt_state == FILT_WAIT) || (nxt_state == VOL_WAIT);
  assign filt_any    = |(filt_snap & ~mute_snap);
  assign wd_expire   = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(WD_LIMIT));
  assign busy_o      = (cur_state != IDLE);
  assign voice_idx_o = cnt;

  // Pick the per-voice snapshot bits for the voice currently addressed by cnt.
  always_comb begin
    mute_sel = 1'b0;
    filt_sel = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (cnt == IDX_W'(i)) begin
        mute_sel = mute_snap[i];
        filt_sel = filt_snap[i];
      end
    end
  end

  // Route the handshake belonging to the current wait state to the exit/watchdog logic.
  always_comb begin
    cur_ready = 1'b0;
    case (cur_state)
      SYN_WAIT:  cur_ready = voice_ready_i;
      ENV_WAIT:  cur_ready = env_ready_i;
      FILT_WAIT: cur_ready = filt_ready_i;
      VOL_WAIT:  cur_ready = mult_ready_i;
      default:   cur_ready = 1'b0;
    endcase
  end

  // State, voice counter, frame snapshots, watchdog and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_state     <= IDLE;
      cnt           <= '0;
      mute_snap     <= '0;
      filt_snap     <= '0;
      wd_cnt        <= '0;
      voice_start_o <= 1'b0;
      env_start_o   <= 1'b0;
      filt_start_o  <= 1'b0;
      mult_start_o  <= 1'b0;
      mult_in_mux_o <= 2'd0;
      accum_en_o    <= 1'b0;
      accum_rst_o   <= 1'b0;
      accum_mux_o   <= 1'b0;
      audio_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_d;
      if (cur_state == IDLE && sample_tick_i) begin
        mute_snap <= voice_mute_i;
        filt_snap <= filt_en_i;
      end
      if (nxt_in_wait && (nxt_state != cur_state)) begin
        wd_cnt <= '0;
      end else if (in_wait && !cur_ready && (TIMEOUT_CYCLES != 0)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      voice_start_o <= voice_start_d;
      env_start_o   <= env_start_d;
      filt_start_o  <= filt_start_d;
      mult_start_o  <= mult_start_d;
      mult_in_mux_o <= mult_in_mux_d;
      accum_en_o    <= accum_en_d;
      accum_rst_o   <= accum_rst_d;
      accum_mux_o   <= accum_mux_d;
      audio_valid_o <= audio_valid_d;
      overrun_o     <= overrun_d;
      timeout_o     <= timeout_d;
    end
  end

  // Next-state and voice-counter update; a ready in the expiry cycle beats the watchdog.
  always_comb begin
    nxt_state = cur_state;
    cnt_d     = cnt;
    case (cur_state)
      IDLE: begin
        if (sample_tick_i) begin
          nxt_state = SEL;
          cnt_d     = '0;
        end
      end
      SEL: begin
        if (cnt == IDX_W'(NUM_VOICES)) begin
          nxt_state = filt_any ? FILT : VOL;
        end else if (mute_sel) begin
          cnt_d = cnt + 1'b1;
        end else begin
          nxt_state = SYN;
        end
      end
      SYN:       nxt_state = SYN_WAIT;
      SYN_WAIT:  if (cur_ready) nxt_state = ENV;   else if (wd_expire) nxt_state = IDLE;
      ENV:       nxt_state = ENV_WAIT;
      ENV_WAIT:  if (cur_ready) nxt_state = ACCUM; else if (wd_expire) nxt_state = IDLE;
      ACCUM: begin
        cnt_d     = cnt + 1'b1;
        nxt_state = SEL;
      end
      FILT:      nxt_state = FILT_WAIT;
      FILT_WAIT: if (cur_ready) nxt_state = VOL;   else if (wd_expire) nxt_state = IDLE;
      VOL:       nxt_state = VOL_WAIT;
      VOL_WAIT:  if (cur_ready) nxt_state = DONE;  else if (wd_expire) nxt_state = IDLE;
      DONE:      nxt_state = IDLE;
      default:   nxt_state = IDLE;
    endcase
  end

  // Output decode from the current state; these values appear on the ports one cycle later.
  always_comb begin
    voice_start_d = 1'b0;
    env_start_d   = 1'b0;
    filt_start_d  = 1'b0;
    mult_start_d  = 1'b0;
    mult_in_mux_d = 2'd0;
    accum_en_d    = 1'b0;
    accum_rst_d   = 1'b0;
    accum_mux_d   = 1'b0;
    audio_valid_d = 1'b0;
    case (cur_state)
      IDLE:      accum_rst_d = 1'b1;
      SYN:       voice_start_d = 1'b1;
      ENV:       env_start_d = 1'b1;
      ACCUM: begin
        accum_en_d  = 1'b1;
        accum_mux_d = filt_sel;
      end
      FILT: begin
        filt_start_d  = 1'b1;
        mult_in_mux_d = 2'd1;
      end
      FILT_WAIT: mult_in_mux_d = 2'd1;
      VOL: begin
        mult_start_d  = 1'b1;
        mult_in_mux_d = 2'd2;
      end
      VOL_WAIT:  mult_in_mux_d = 2'd2;
      DONE:      audio_valid_d = 1'b1;
      default:   ;
    endcase
    overrun_d = sample_tick_i && (cur_state != IDLE);
    timeout_d = in_wait && !cur_ready && wd_expire;
  end

endmodule
